// File: rtl/bullet_hit_score.sv
// bullet_hit_score
// Two-tank bullet hit detection, lives/score keeping and round FSM.
// All FSM/lives/counter/winner updates happen on the one-Clk frame tick
// derived from frame_clk; bullet_clear pulses follow a strike by one Clk.
//
// Ports:
//   Clk, Reset                 system clock, synchronous active-high reset
//   frame_clk                  ~60 Hz frame strobe (asynchronous level)
//   keycode[7:0]               current keyboard keycode
//   tankN_X/Y[9:0]             tank top-left pixel
//   bulletN_X/Y[9:0]           bullet top-left pixel (bulletN fired by tankN)
//   hitN[1:0]                  2'b01 = tankN's bullet in flight
//   livesN[1:0]                remaining lives
//   game_state[1:0]            00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//   freeze                     tanks must not move or fire
//   bullet_clearN              one-Clk pulse: retire tankN's bullet
//   tankN_flash                blink enable for a struck tank sprite
//   winner[1:0]                00 none, 01 tank1, 10 tank2, 11 draw
module bullet_hit_score #(
    parameter int          TANK_W       = 32,
    parameter int          TANK_H       = 32,
    parameter int          BUL_W        = 8,
    parameter int          BUL_H        = 8,
    parameter int          LIVES        = 3,
    parameter int          FLASH_FRAMES = 60,
    parameter logic [7:0]  START_KEY    = 8'h29
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] tank1_X,
    input  logic [9:0] tank1_Y,
    input  logic [9:0] tank2_X,
    input  logic [9:0] tank2_Y,
    input  logic [9:0] bullet1_X,
    input  logic [9:0] bullet1_Y,
    input  logic [9:0] bullet2_X,
    input  logic [9:0] bullet2_Y,
    input  logic [1:0] hit1,
    input  logic [1:0] hit2,
    output logic [1:0] lives1,
    output logic [1:0] lives2,
    output logic [1:0] game_state,
    output logic       freeze,
    output logic       bullet_clear1,
    output logic       bullet_clear2,
    output logic       tank1_flash,
    output logic       tank2_flash,
    output logic [1:0] winner
);

    // Counter is at least 4 bits wide so bit 3 always exists for the blink.
    localparam int CW = ($clog2(FLASH_FRAMES + 1) < 4) ? 4 : $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    state_t          r_state, w_state_n;
    logic [1:0]      r_lives1, r_lives2, w_lives1_n, w_lives2_n;
    logic [1:0]      r_winner, w_winner_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            r_struck1, r_struck2, w_struck1_n, w_struck2_n;
    logic            r_clear1, r_clear2, w_clear1_n, w_clear2_n;
    logic            r_fc_q, r_fc_prev, r_tick;
    logic            w_str1, w_str2, w_key;

    // Inclusive-bounds bullet/tank overlap in 11-bit unsigned arithmetic.
    function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] tx, input logic [9:0] ty);
        logic [10:0] w_bx, w_by, w_tx, w_ty;
        w_bx = {1'b0, bx};
        w_by = {1'b0, by};
        w_tx = {1'b0, tx};
        w_ty = {1'b0, ty};
        return (w_bx <= w_tx + 11'(TANK_W)) && (w_bx + 11'(BUL_W) >= w_tx) &&
               (w_by <= w_ty + 11'(TANK_H)) && (w_by + 11'(BUL_H) >= w_ty);
    endfunction

    // w_strN: tankN struck by the other tank's bullet (never its own).
    assign w_str2 = (hit1 == 2'b01) && overlap(bullet1_X, bullet1_Y, tank2_X, tank2_Y);
    assign w_str1 = (hit2 == 2'b01) && overlap(bullet2_X, bullet2_Y, tank1_X, tank1_Y);
    assign w_key  = (keycode == START_KEY);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_q    <= 1'b0;
            r_fc_prev <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_fc_q    <= frame_clk;
            r_fc_prev <= r_fc_q;
            r_tick    <= r_fc_q & ~r_fc_prev;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_lives1  <= 2'(LIVES);
            r_lives2  <= 2'(LIVES);
            r_winner  <= '0;
            r_cnt     <= '0;
            r_struck1 <= 1'b0;
            r_struck2 <= 1'b0;
            r_clear1  <= 1'b0;
            r_clear2  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lives1  <= w_lives1_n;
            r_lives2  <= w_lives2_n;
            r_winner  <= w_winner_n;
            r_cnt     <= w_cnt_n;
            r_struck1 <= w_struck1_n;
            r_struck2 <= w_struck2_n;
            r_clear1  <= w_clear1_n;
            r_clear2  <= w_clear2_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_lives1_n  = r_lives1;
        w_lives2_n  = r_lives2;
        w_winner_n  = r_winner;
        w_cnt_n     = r_cnt;
        w_struck1_n = r_struck1;
        w_struck2_n = r_struck2;
        w_clear1_n  = 1'b0;
        w_clear2_n  = 1'b0;
        if (r_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_lives1_n = 2'(LIVES);
                    w_lives2_n = 2'(LIVES);
                    if (w_key) w_state_n = ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_str1 || w_str2) begin
                        // The shooter's bullet is retired, not the victim's.
                        w_clear1_n  = w_str2;
                        w_clear2_n  = w_str1;
                        w_struck1_n = w_str1;
                        w_struck2_n = w_str2;
                        if (w_str1 && r_lives1 != 2'd0) w_lives1_n = r_lives1 - 2'd1;
                        if (w_str2 && r_lives2 != 2'd0) w_lives2_n = r_lives2 - 2'd1;
                        if (w_lives1_n == 2'd0 || w_lives2_n == 2'd0) begin
                            w_state_n  = ST_OVER;
                            w_winner_n = {w_lives1_n == 2'd0, w_lives2_n == 2'd0};
                            w_cnt_n    = '0;
                        end else begin
                            w_state_n = ST_HIT;
                            w_cnt_n   = CW'(FLASH_FRAMES);
                        end
                    end
                end
                ST_HIT: begin
                    if (r_cnt <= CW'(1)) begin
                        w_state_n = ST_PLAY;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt - CW'(1);
                    end
                end
                ST_OVER: begin
                    if (w_key) begin
                        w_state_n  = ST_IDLE;
                        w_lives1_n = 2'(LIVES);
                        w_lives2_n = 2'(LIVES);
                        w_winner_n = '0;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    assign lives1        = r_lives1;
    assign lives2        = r_lives2;
    assign winner        = r_winner;
    assign game_state    = r_state;
    assign freeze        = (r_state != ST_PLAY);
    assign bullet_clear1 = r_clear1;
    assign bullet_clear2 = r_clear2;
    assign tank1_flash   = (r_state == ST_HIT) && r_struck1 && r_cnt[3];
    assign tank2_flash   = (r_state == ST_HIT) && r_struck2 && r_cnt[3];

endmodule

// File: tb/tb_bullet_hit_score.sv
// tb_bullet_hit_score
// Directed bench for bullet_hit_score: reset state, start key, strike
// geometry boundaries, HIT duration and blink, mutual strikes, OVER/winner,
// restart and reset during HIT.
module tb_bullet_hit_score;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] tank1_X, tank1_Y, tank2_X, tank2_Y;
    logic [9:0] bullet1_X, bullet1_Y, bullet2_X, bullet2_Y;
    logic [1:0] hit1, hit2;
    logic [1:0] lives1, lives2, game_state, winner;
    logic       freeze, bullet_clear1, bullet_clear2, tank1_flash, tank2_flash;

    int n_vec = 0;
    int n_err = 0;
    int c1, c2;

    bullet_hit_score #(
        .TANK_W(32), .TANK_H(32), .BUL_W(8), .BUL_H(8),
        .LIVES(3), .FLASH_FRAMES(60), .START_KEY(8'h29)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .tank1_X(tank1_X), .tank1_Y(tank1_Y), .tank2_X(tank2_X), .tank2_Y(tank2_Y),
        .bullet1_X(bullet1_X), .bullet1_Y(bullet1_Y),
        .bullet2_X(bullet2_X), .bullet2_Y(bullet2_Y),
        .hit1(hit1), .hit2(hit2),
        .lives1(lives1), .lives2(lives2), .game_state(game_state), .freeze(freeze),
        .bullet_clear1(bullet_clear1), .bullet_clear2(bullet_clear2),
        .tank1_flash(tank1_flash), .tank2_flash(tank2_flash), .winner(winner)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame_clk pulse spanning 8 Clk cycles; counts clear pulse cycles.
    task automatic do_tick();
        c1 = 0;
        c2 = 0;
        frame_clk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            c1 += int'(bullet_clear1);
            c2 += int'(bullet_clear2);
            if (i == 2) frame_clk = 1'b0;
        end
    endtask

    // Spend a whole HIT phase: 59 ticks still in HIT, the 60th returns to PLAY.
    task automatic ride_hit(input int l1, input int l2);
        for (int k = 0; k < 59; k++) do_tick();
        chk("hit_59_state", game_state, 2);
        chk("hit_59_lives1", lives1, l1);
        chk("hit_59_lives2", lives2, l2);
        do_tick();
        chk("hit_60_state", game_state, 1);
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        keycode = 8'h00;
        tank1_X = 10'd400; tank1_Y = 10'd300;
        tank2_X = 10'd100; tank2_Y = 10'd100;
        bullet1_X = 10'd0; bullet1_Y = 10'd0;
        bullet2_X = 10'd0; bullet2_Y = 10'd0;
        hit1 = 2'b00; hit2 = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_state", game_state, 0);
        chk("rst_lives1", lives1, 3);
        chk("rst_lives2", lives2, 3);
        chk("rst_winner", winner, 0);
        chk("rst_freeze", freeze, 1);
        chk("rst_clears", {bullet_clear1, bullet_clear2}, 0);
        chk("rst_flash", {tank1_flash, tank2_flash}, 0);
        Reset = 1'b0;

        // IDLE without the start key stays IDLE
        do_tick();
        chk("idle_nokey", game_state, 0);

        keycode = 8'h29;
        do_tick();
        keycode = 8'h00;
        chk("start_state", game_state, 1);
        chk("start_freeze", freeze, 0);
        chk("start_lives", {lives1, lives2}, 4'b1111);

        // Miss: bullet1_X one past the right edge
        bullet1_X = 10'd133; bullet1_Y = 10'd116; hit1 = 2'b01;
        do_tick();
        chk("miss_x133_state", game_state, 1);
        chk("miss_x133_lives2", lives2, 3);
        chk("miss_x133_clear", c1, 0);

        // Overlap but bullet status not in flight
        bullet1_X = 10'd132; hit1 = 2'b11;
        do_tick();
        chk("status11_state", game_state, 1);
        chk("status11_lives2", lives2, 3);

        // Left/bottom/top edges one pixel out
        hit1 = 2'b01;
        bullet1_X = 10'd91; bullet1_Y = 10'd116;
        do_tick();
        chk("miss_x91", lives2, 3);
        bullet1_X = 10'd116; bullet1_Y = 10'd133;
        do_tick();
        chk("miss_y133", lives2, 3);
        bullet1_X = 10'd116; bullet1_Y = 10'd91;
        do_tick();
        chk("miss_y91", lives2, 3);

        // Own bullet over own tank never strikes; start key ignored in PLAY
        bullet1_X = 10'd0; bullet1_Y = 10'd0;
        bullet2_X = 10'd104; bullet2_Y = 10'd104; hit2 = 2'b00;
        hit1 = 2'b00;
        bullet1_X = 10'd404; bullet1_Y = 10'd304; hit1 = 2'b01;
        keycode = 8'h29;
        do_tick();
        keycode = 8'h00;
        chk("own_tank_state", game_state, 1);
        chk("own_tank_lives", {lives1, lives2}, 4'b1111);

        // Strike on the right edge: bullet1 (132,116) vs tank2 (100,100)
        bullet1_X = 10'd132; bullet1_Y = 10'd116; hit1 = 2'b01;
        bullet2_X = 10'd0; bullet2_Y = 10'd0; hit2 = 2'b00;
        do_tick();
        chk("strike_lives2", lives2, 2);
        chk("strike_lives1", lives1, 3);
        chk("strike_clear1_cycles", c1, 1);
        chk("strike_clear2_cycles", c2, 0);
        chk("strike_state", game_state, 2);
        chk("strike_freeze", freeze, 1);
        chk("strike_flash2_60", tank2_flash, 1);
        chk("strike_flash1", tank1_flash, 0);

        // Both bullets overlapping throughout HIT: no further strikes
        bullet2_X = 10'd400; bullet2_Y = 10'd300; hit2 = 2'b01;
        for (int k = 1; k < 60; k++) begin
            do_tick();
            chk("hit_state", game_state, 2);
            chk("hit_flash2", tank2_flash, ((60 - k) >> 3) & 1);
            chk("hit_flash1", tank1_flash, 0);
            chk("hit_lives", {lives1, lives2}, 4'b1110);
            chk("hit_clears", c1 + c2, 0);
        end
        do_tick();
        chk("hit_end_state", game_state, 1);
        chk("hit_end_freeze", freeze, 0);
        chk("hit_end_lives", {lives1, lives2}, 4'b1110);

        // Mutual strike at the corner bounds
        bullet1_X = 10'd92;  bullet1_Y = 10'd92;
        bullet2_X = 10'd432; bullet2_Y = 10'd332;
        do_tick();
        chk("mutual_lives1", lives1, 2);
        chk("mutual_lives2", lives2, 1);
        chk("mutual_clear1", c1, 1);
        chk("mutual_clear2", c2, 1);
        chk("mutual_state", game_state, 2);
        chk("mutual_flash", {tank1_flash, tank2_flash}, 2'b11);

        // Reset in the middle of HIT
        do_tick();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("midhit_rst_state", game_state, 0);
        chk("midhit_rst_lives", {lives1, lives2}, 4'b1111);
        chk("midhit_rst_flash", {tank1_flash, tank2_flash}, 0);
        chk("midhit_rst_freeze", freeze, 1);
        Reset = 1'b0;

        // Tank2 loses all lives: winner tank1
        hit2 = 2'b00;
        keycode = 8'h29;
        do_tick();
        keycode = 8'h00;
        chk("restart_state", game_state, 1);
        bullet1_X = 10'd132; bullet1_Y = 10'd116;
        do_tick();
        chk("t2_hit1_lives2", lives2, 2);
        ride_hit(3, 2);
        do_tick();
        chk("t2_hit2_lives2", lives2, 1);
        ride_hit(3, 1);
        do_tick();
        chk("t2_over_state", game_state, 3);
        chk("t2_over_lives", {lives1, lives2}, 4'b1100);
        chk("t2_over_winner", winner, 1);
        chk("t2_over_clear1", c1, 1);
        chk("t2_over_freeze", freeze, 1);

        // OVER holds without the key
        do_tick();
        chk("over_hold_state", game_state, 3);
        chk("over_hold_winner", winner, 1);

        keycode = 8'h29;
        do_tick();
        chk("over_restart_state", game_state, 0);
        chk("over_restart_lives", {lives1, lives2}, 4'b1111);
        chk("over_restart_winner", winner, 0);

        // Mutual strikes down to a draw (key still held: IDLE -> PLAY)
        do_tick();
        keycode = 8'h00;
        chk("draw_play", game_state, 1);
        bullet2_X = 10'd400; bullet2_Y = 10'd300; hit2 = 2'b01;
        do_tick();
        chk("draw_1_lives", {lives1, lives2}, 4'b1010);
        ride_hit(2, 2);
        do_tick();
        chk("draw_2_lives", {lives1, lives2}, 4'b0101);
        ride_hit(1, 1);
        do_tick();
        chk("draw_lives", {lives1, lives2}, 4'b0000);
        chk("draw_clears", {c1[1:0], c2[1:0]}, 4'b0101);
        chk("draw_state", game_state, 3);
        chk("draw_winner", winner, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bullet_hit_score.md
BULLET_HIT_SCORE -- requirements
Module: bullet_hit_score

Interface
REQ-001 Parameters SHALL be: TANK_W 32 tank width; TANK_H 32 tank height; BUL_W 8 bullet width; BUL_H 8 bullet height; LIVES 3 starting lives per tank; FLASH_FRAMES 60 frames frozen after a hit; START_KEY 8'h29 (Esc) start/restart keycode.
REQ-002 Clk  in  1  50 MHz system clock; the only clock; all state updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 frame_clk  in  1  ~60 Hz frame strobe from VGA controller.
REQ-005 keycode  in  8  current keyboard keycode.
REQ-006 tank1_X, tank1_Y, tank2_X, tank2_Y  in  10 each  tank top-left pixel, unsigned.
REQ-007 bullet1_X, bullet1_Y, bullet2_X, bullet2_Y  in  10 each  bullet top-left pixel; bulletN belongs to tankN.
REQ-008 hit1, hit2  in  2 each  bullet status of tankN: 2'b01 = bullet in flight; any other value = no live bullet.
REQ-009 lives1, lives2  out  2 each  remaining lives.
REQ-010 game_state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
REQ-011 freeze  out  1  high = tanks must not move or fire.
REQ-012 bullet_clear1, bullet_clear2  out  1 each  one-Clk pulse: tankN's bullet struck and must be retired.
REQ-013 tank1_flash, tank2_flash  out  1 each  blink enable for the struck tank's sprite.
REQ-014 winner  out  2  00 none, 01 tank1, 10 tank2, 11 draw.

Function
REQ-015 frame_tick SHALL be generated as in the existing frame logic: frame_clk registered once; tick registered high for exactly one Clk cycle when current sample is 1 and previous sample is 0.
REQ-016 All FSM, lives, counter and winner updates SHALL occur only in a cycle with frame_tick high, except bullet_clear pulses and Reset.
REQ-017 Hit test SHALL use 11-bit unsigned arithmetic, inclusive bounds: bullet1 strikes tank2 iff hit1==01 and bullet1_X <= tank2_X+TANK_W and bullet1_X+BUL_W >= tank2_X and bullet1_Y <= tank2_Y+TANK_H and bullet1_Y+BUL_H >= tank2_Y; symmetric for bullet2 vs tank1.
REQ-018 A bullet SHALL never strike its own tank.
REQ-019 IDLE: lives held at LIVES; freeze=1; on frame_tick with keycode==START_KEY go PLAY.
REQ-020 PLAY: freeze=0; on frame_tick evaluate both hit tests; if neither, stay PLAY.
REQ-021 On a strike of tankN, livesN SHALL decrement by 1, saturating at 0; the shooter's bullet_clear SHALL pulse high in the Clk cycle after the tick for exactly one cycle.
REQ-022 Simultaneous strikes SHALL decrement both lives and pulse both bullet_clear outputs in the same cycle.
REQ-023 After a strike, if any lives reach 0 go OVER; else load flash counter with FLASH_FRAMES and go HIT.
REQ-024 OVER entry SHALL set winner: only lives2==0 -> 01; only lives1==0 -> 10; both 0 -> 11.
REQ-025 HIT: freeze=1; counter decrements by 1 per frame_tick; on tick with counter==1 go PLAY (exactly FLASH_FRAMES ticks spent in HIT); strikes not evaluated.
REQ-026 tankN_flash SHALL equal counter bit 3 while in HIT and tankN was struck in the triggering event; 0 otherwise.
REQ-027 OVER: freeze=1; lives and winner held; on frame_tick with keycode==START_KEY go IDLE, reload both lives to LIVES, winner to 00.
REQ-028 START_KEY outside IDLE/OVER SHALL be ignored.

Reset
REQ-029 Reset SHALL, on the next Clk edge from any state: game_state IDLE, lives1=lives2=LIVES, winner 00, counter 0, freeze 1, bullet_clear1/2 0, tank1/2_flash 0, frame edge registers 0.
REQ-030 Reset asserted during HIT or in the cycle of a bullet_clear pulse SHALL suppress that pulse and discard the pending strike.

Verification
REQ-031 Reset, then Esc on a tick -> game_state 01, freeze 0, lives 3/3.
REQ-032 PLAY, tank2 at (100,100), bullet1 at (132,116), hit1=01, tick -> lives2=2, bullet_clear1 one-cycle pulse, state 10, tank2_flash toggles every 8 ticks.
REQ-033 Same geometry with bullet1_X=133 -> no strike; state stays 01.
REQ-034 Mutual overlap with lives 1/1 on same tick -> lives 0/0, both clears pulse, state 11, winner 11.
REQ-035 In HIT, count ticks -> exactly 60 ticks then state 01; overlapping bullets during HIT -> lives unchanged.
REQ-036 In OVER, Esc on tick -> state 00, lives 3/3, winner 00; Reset mid-HIT -> state 00 next cycle.
